// File: rtl/de0_avalon_cmd_master.sv
// Avalon-MM command initiator: one local command becomes one Avalon read or
// write toward the PIO/register slaves, with exactly one response per command.
// A wait counter aborts transfers stalled by a hung slave.
module de0_avalon_cmd_master #(
  parameter int ADDR_W  = 2,
  parameter int RD_LAT  = 0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest
);

  // Wait counter only needs to reach TIMEOUT-1; the abort fires on the edge
  // that would count the TIMEOUT-th stalled cycle.
  localparam int              TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [2:0]      LAT     = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, XFER, RDWAIT, RSP} state_t;

  state_t        state;
  logic          wr_q;
  logic [TW-1:0] wait_cnt;
  logic [2:0]    lat_cnt;

  // Commands are only taken in IDLE, never while reset is asserted.
  assign cmd_ready = (state == IDLE) && !reset;

  // Transfer sequencer; every bus and response output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      wait_cnt     <= '0;
      lat_cnt      <= '0;
      m_address    <= '0;
      m_writedata  <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            m_address    <= cmd_addr;
            m_writedata  <= cmd_wdata;
            m_write_n    <= ~cmd_write;
            m_chipselect <= 1'b1;
            wr_q         <= cmd_write;
            wait_cnt     <= '0;
            state        <= XFER;
          end
        end
        XFER: begin
          // chipselect is always high here, so !waitrequest is the acceptance
          // edge; it takes priority over a timeout on the same edge.
          if (!m_waitrequest) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            if (wr_q) begin
              rsp_valid <= 1'b1;
              rsp_write <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
              state     <= RSP;
            end else if (RD_LAT == 0) begin
              rsp_valid <= 1'b1;
              rsp_write <= 1'b0;
              rsp_rdata <= m_readdata;
              rsp_err   <= 1'b0;
              state     <= RSP;
            end else begin
              lat_cnt <= 3'd1;
              state   <= RDWAIT;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            rsp_valid    <= 1'b1;
            rsp_write    <= wr_q;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b1;
            state        <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RDWAIT: begin
          // lat_cnt holds the number of edges elapsed since acceptance.
          if (lat_cnt == LAT) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= m_readdata;
            rsp_err   <= 1'b0;
            state     <= RSP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
